// File: rtl/control_pkg.sv
// Shared types and constants for the matrix-multiply control unit.
package control_pkg;

  localparam int unsigned      DEF_ADDR_W     = 16;
  localparam logic [15:0]      DEF_START_ADDR = 16'd0;

  // Sequencer state; FAULT is only reachable with the watchdog built in.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    HALT  = 2'd2,
    FAULT = 2'd3
  } seq_state_e;

  // Branch condition field encodings from the microcode ROM.
  localparam logic [1:0] COND_ALWAYS = 2'b00;
  localparam logic [1:0] COND_ZERO   = 2'b01;
  localparam logic [1:0] COND_DONE   = 2'b10;
  localparam logic [1:0] COND_EXT    = 2'b11;

endpackage

// File: rtl/micro_next_addr.sv
// Combinational next-address logic: flag select, branch taken, next upc and
// self-loop halt detection.
module micro_next_addr
  import control_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic [ADDR_W-1:0] upc,
  input  logic [1:0]        condition,
  input  logic              BT,
  input  logic [ADDR_W-1:0] jump_addr,
  input  logic              zero_flag,
  input  logic              done_flag,
  input  logic              ext_flag,
  output logic [ADDR_W-1:0] next_upc,
  output logic              taken,
  output logic              halt
);

  logic flag_sel;

  // Pick the tested flag, resolve the branch and form the next address.
  always_comb begin
    flag_sel = 1'b1;
    case (condition)
      COND_ALWAYS: flag_sel = 1'b1;
      COND_ZERO:   flag_sel = zero_flag;
      COND_DONE:   flag_sel = done_flag;
      COND_EXT:    flag_sel = ext_flag;
      default:     flag_sel = 1'b1;
    endcase
    taken    = BT & flag_sel;
    next_upc = taken ? jump_addr : upc + ADDR_W'(1);
    halt     = taken & (jump_addr == upc);
  end

endmodule

// File: rtl/micro_sequencer.sv
// Micro-program counter with start/halt handshake and stall support.
// Optional watchdog fault on long stalls: define MICRO_SEQUENCER_WATCHDOG_EN.
module micro_sequencer
  import control_pkg::*;
#(
  parameter int unsigned       ADDR_W     = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0] START_ADDR = ADDR_W'(DEF_START_ADDR),
  parameter int unsigned       WDT_LIMIT  = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stall,
  input  logic [1:0]        condition,
  input  logic              BT,
  input  logic [ADDR_W-1:0] jump_addr,
  input  logic              zero_flag,
  input  logic              done_flag,
  input  logic              ext_flag,
  output logic [ADDR_W-1:0] upc,
  output logic              uop_valid,
  output logic              busy,
  output logic              done,
  output logic              fault
);

  seq_state_e        state_q;
  logic [ADDR_W-1:0] upc_q;
  logic              busy_q;
  logic              done_q;
  logic [ADDR_W-1:0] next_upc;
  logic              taken;
  logic              halt;

  micro_next_addr #(.ADDR_W(ADDR_W)) u_next_addr (
    .upc       (upc_q),
    .condition (condition),
    .BT        (BT),
    .jump_addr (jump_addr),
    .zero_flag (zero_flag),
    .done_flag (done_flag),
    .ext_flag  (ext_flag),
    .next_upc  (next_upc),
    .taken     (taken),
    .halt      (halt)
  );

`ifdef MICRO_SEQUENCER_WATCHDOG_EN
  localparam int unsigned WDT_W = $clog2(WDT_LIMIT + 1);
  logic [WDT_W-1:0] wdt_q;
  logic             fault_q;

  // Sequencer FSM with registered outputs and stall watchdog.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      upc_q   <= START_ADDR;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
      wdt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          upc_q <= START_ADDR;
          if (start) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
            wdt_q   <= '0;
          end
        end
        RUN: begin
          if (!stall) begin
            wdt_q <= '0;
            upc_q <= next_upc;
            if (halt) begin
              state_q <= HALT;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end else if (wdt_q == WDT_W'(WDT_LIMIT - 1)) begin
            state_q <= FAULT;
            busy_q  <= 1'b0;
            fault_q <= 1'b1;
          end else begin
            wdt_q <= wdt_q + WDT_W'(1);
          end
        end
        HALT: begin
          if (start) begin
            state_q <= RUN;
            upc_q   <= START_ADDR;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            wdt_q   <= '0;
          end
        end
        FAULT: ;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign fault = fault_q;
`else
  // Sequencer FSM with registered outputs; stalls may last indefinitely.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      upc_q   <= START_ADDR;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          upc_q <= START_ADDR;
          if (start) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
          end
        end
        RUN: begin
          if (!stall) begin
            upc_q <= next_upc;
            if (halt) begin
              state_q <= HALT;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        HALT: begin
          if (start) begin
            state_q <= RUN;
            upc_q   <= START_ADDR;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign fault = 1'b0;
`endif

  assign upc       = upc_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign uop_valid = (state_q == RUN) & ~stall;

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed self-checking bench for micro_sequencer.
module tb_micro_sequencer;
  import control_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        stall;
  logic [1:0]  condition;
  logic        BT;
  logic [15:0] jump_addr;
  logic        zero_flag;
  logic        done_flag;
  logic        ext_flag;
  logic [15:0] upc;
  logic        uop_valid;
  logic        busy;
  logic        done;
  logic        fault;

  int checks;
  int failures;

  micro_sequencer #(
    .ADDR_W     (16),
    .START_ADDR (16'd0),
    .WDT_LIMIT  (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .stall     (stall),
    .condition (condition),
    .BT        (BT),
    .jump_addr (jump_addr),
    .zero_flag (zero_flag),
    .done_flag (done_flag),
    .ext_flag  (ext_flag),
    .upc       (upc),
    .uop_valid (uop_valid),
    .busy      (busy),
    .done      (done),
    .fault     (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic word(input logic bt, input logic [1:0] cnd, input logic [15:0] ja);
    BT        = bt;
    condition = cnd;
    jump_addr = ja;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    stall     = 1'b0;
    zero_flag = 1'b0;
    done_flag = 1'b0;
    ext_flag  = 1'b0;
    word(1'b0, COND_ALWAYS, 16'h0000);
    step();
    step();
    check("rst_upc", upc, 32'h0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_fault", fault, 0);
    check("rst_valid", uop_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("idle_upc", upc, 32'h0);
    check("idle_busy", busy, 0);

    // Start and sequential fetch
    start = 1'b1;
    step();
    start = 1'b0;
    check("run_upc0", upc, 32'h0);
    check("run_busy", busy, 1);
    check("run_valid0", uop_valid, 1);
    for (int i = 1; i <= 5; i++) begin
      step();
      check("seq_upc", upc, i);
      check("seq_valid", uop_valid, 1);
    end

    // Conditional branch on zero_flag, taken and not taken
    word(1'b1, COND_ZERO, 16'h0040);
    zero_flag = 1'b1;
    step();
    check("br_zero_taken", upc, 32'h40);
    word(1'b1, COND_ALWAYS, 16'h0005);
    zero_flag = 1'b0;
    step();
    check("br_always", upc, 32'h5);
    word(1'b1, COND_ZERO, 16'h0040);
    step();
    check("br_zero_not", upc, 32'h6);
    word(1'b1, COND_DONE, 16'h0009);
    done_flag = 1'b1;
    step();
    done_flag = 1'b0;
    check("br_done_taken", upc, 32'h9);

    // Stall with a pending branch word: nothing evaluated
    stall = 1'b1;
    word(1'b1, COND_ALWAYS, 16'h0030);
    #1;
    check("stall_valid_comb", uop_valid, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_upc", upc, 32'h9);
      check("stall_valid", uop_valid, 0);
      check("stall_busy", busy, 1);
    end
    stall = 1'b0;
    word(1'b0, COND_ALWAYS, 16'h0000);
    #1;
    check("unstall_valid", uop_valid, 1);
    step();
    check("unstall_upc", upc, 32'hA);

    // External flag branch, not taken then taken
    word(1'b1, COND_EXT, 16'h0050);
    ext_flag = 1'b0;
    step();
    check("br_ext_not", upc, 32'hB);
    word(1'b1, COND_EXT, 16'h0012);
    ext_flag = 1'b1;
    step();
    ext_flag = 1'b0;
    check("br_ext_taken", upc, 32'h12);

    // Halt word, first under stall (stall wins), then executed once
    word(1'b1, COND_ALWAYS, 16'h0012);
    stall = 1'b1;
    step();
    check("halt_stall_upc", upc, 32'h12);
    check("halt_stall_done", done, 0);
    check("halt_stall_busy", busy, 1);
    stall = 1'b0;
    #1;
    check("halt_word_valid", uop_valid, 1);
    step();
    check("halt_done", done, 1);
    check("halt_busy", busy, 0);
    check("halt_upc", upc, 32'h12);
    check("halt_valid", uop_valid, 0);
    step();
    check("halt_hold_upc", upc, 32'h12);
    check("halt_hold_done", done, 1);
    start = 1'b1;
    step();
    start = 1'b0;
    check("restart_upc", upc, 32'h0);
    check("restart_done", done, 0);
    check("restart_busy", busy, 1);

    // Address wrap
    word(1'b1, COND_ALWAYS, 16'hFFFF);
    step();
    check("jump_ffff", upc, 32'hFFFF);
    check("jump_ffff_busy", busy, 1);
    word(1'b0, COND_ALWAYS, 16'h0000);
    step();
    check("wrap_upc", upc, 32'h0);
    step();
    check("post_wrap_upc", upc, 32'h1);

    // Asynchronous reset between edges
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_upc", upc, 32'h0);
    check("async_rst_busy", busy, 0);
    check("async_rst_valid", uop_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;

    start = 1'b1;
    step();
    start = 1'b0;
    check("wdt_start_upc", upc, 32'h0);
`ifdef MICRO_SEQUENCER_WATCHDOG_EN
    stall = 1'b1;
    for (int i = 0; i < 7; i++) step();
    check("wdt7_fault", fault, 0);
    stall = 1'b0;
    step();
    check("wdt_release_upc", upc, 32'h1);
    stall = 1'b1;
    for (int i = 0; i < 7; i++) step();
    check("wdt7b_fault", fault, 0);
    check("wdt7b_busy", busy, 1);
    step();
    check("wdt8_fault", fault, 1);
    check("wdt8_busy", busy, 0);
    check("wdt8_valid", uop_valid, 0);
    check("wdt8_upc", upc, 32'h1);
    stall = 1'b0;
    start = 1'b1;
    step();
    step();
    start = 1'b0;
    check("fault_sticky", fault, 1);
    check("fault_busy", busy, 0);
    check("fault_upc", upc, 32'h1);
    check("fault_valid", uop_valid, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("fault_rst", fault, 0);
`else
    stall = 1'b1;
    for (int i = 0; i < 12; i++) step();
    check("long_stall_fault", fault, 0);
    check("long_stall_busy", busy, 1);
    check("long_stall_upc", upc, 32'h0);
    stall = 1'b0;
    step();
    check("long_stall_resume", upc, 32'h1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/micro_sequencer.md
Name: micro_sequencer

Overview:
- Micro-program counter and next-address logic for the matrix-multiply control unit.
- Drives the 16-bit address into the microcode ROM and consumes the ROM's condition, BT and jump_addr fields to choose the next address.
- Adds start/halt handshake and stall support so the OPs word reaches the datapath cores only when valid.
- Sits directly upstream of the microcode ROM; the ROM's OPs bus passes around this block to the datapath.

Parameters:
- ADDR_W, 16, micro-address width; must match the ROM address input.
- START_ADDR, 16'd0, entry address loaded on start.
- WDT_LIMIT, 1024, consecutive stall cycles before fault (optional feature only).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  level; begin program at START_ADDR when in IDLE or HALT.
- stall  in  1  datapath/memory busy; freeze the sequencer.
- condition  in  2  ROM field; selects branch flag.
- BT  in  1  ROM field; 1 = this microword is a branch.
- jump_addr  in  ADDR_W  ROM field; branch target.
- zero_flag  in  1  ALU zero flag.
- done_flag  in  1  AND of all core-done signals.
- ext_flag  in  1  general external test flag.
- upc  out  ADDR_W  micro-address to the ROM (reg_out).
- uop_valid  out  1  OPs word is to be executed this cycle.
- busy  out  1  program running.
- done  out  1  program reached halt.
- fault  out  1  watchdog fault; constant 0 without the optional feature.

Behaviour:
- Registered state: IDLE, RUN, HALT, plus FAULT with the optional feature. upc, busy, done and fault are registered; uop_valid = (state==RUN) & ~stall, combinational.
- Reset (async, any time including mid-RUN):
  - state=IDLE, upc=START_ADDR.
  - busy=0, done=0, fault=0, hence uop_valid=0.
- IDLE:
  - upc held at START_ADDR.
  - start=1 → RUN on the next edge; busy=1 from that edge.
  - The ROM word at START_ADDR is executed in the first RUN cycle.
- RUN:
  - The ROM is combinational, so the microword for upc and the flags are sampled in the same cycle. Branch resolution takes zero bubbles.
  - flag select: condition 00 → 1 (unconditional), 01 → zero_flag, 10 → done_flag, 11 → ext_flag.
  - taken = BT & flag.
  - If stall=0: upc ← taken ? jump_addr : upc+1. The increment is modulo 2^ADDR_W, so 16'hFFFF → 16'h0000.
  - If stall=1: upc, state and flags are held; uop_valid=0; no branch is evaluated.
  - Halt: if stall=0, taken=1 and jump_addr==upc (self-loop) → HALT next edge.
    - done=1, busy=0.
    - upc stays at the halt address.
    - The halting word is executed once (uop_valid=1 in that cycle).
  - stall=1 together with the halt word: stall wins; halt is evaluated when stall drops.
  - start in RUN is ignored.
- HALT:
  - done held high; uop_valid=0.
  - start=1 → RUN next edge; upc=START_ADDR, done=0, busy=1.
- jump_addr wider than upc never occurs: both are ADDR_W.

Optional Feature:
- Macro: MICRO_SEQUENCER_WATCHDOG_EN.
- Defined:
  - A counter of consecutive RUN stall cycles, cleared on any non-stall cycle and on entry to RUN.
  - When the count reaches WDT_LIMIT, the state moves to FAULT: fault=1, busy=0, uop_valid=0, upc held.
  - FAULT exits only through rst_n.
- Undefined: no counter, no FAULT state, fault tied to 0, and stall may last indefinitely.

Decomposition:
- Shared package control_pkg:
  - state enum (IDLE/RUN/HALT/FAULT).
  - condition encodings COND_ALWAYS=2'b00, COND_ZERO=2'b01, COND_DONE=2'b10, COND_EXT=2'b11.
  - Default ADDR_W and START_ADDR.
- Natural sub-module: micro_next_addr, purely combinational; computes flag select, taken, next upc and halt detect. The top level holds the state register, the upc register and the watchdog.

Test Plan:
- Reset then start=1 for 1 cycle with ROM words BT=0 → upc 0,1,2,3 on consecutive cycles; busy=1; uop_valid=1 every cycle.
- At upc=5: BT=1, condition=01, jump_addr=16'h0040 → zero_flag=1 gives upc=16'h0040 next cycle; zero_flag=0 gives upc=6.
- stall=1 for 3 cycles at upc=9 → upc stays 9 and uop_valid=0 throughout; upc=10 the cycle after stall drops.
- Halt word at upc=16'h0012 (BT=1, condition=00, jump_addr=16'h0012) → one cycle uop_valid=1, then done=1, busy=0, upc=16'h0012 held. start=1 → upc=0, done=0.
- Wrap and reset:
  - upc forced to 16'hFFFF with BT=0 → next upc=16'h0000.
  - rst_n pulled low mid-RUN, between clock edges → immediate upc=0, busy=0, uop_valid=0.
- Watchdog (MICRO_SEQUENCER_WATCHDOG_EN, WDT_LIMIT=8):
  - stall held 8 cycles → fault=1, busy=0; start is ignored until reset.
  - stall for 7 cycles, release 1 cycle, stall 7 more → no fault.
